vram_wr_arbiter: RTL and testbench

- Owns the single write port of the 200x150 12-bit frame-buffer BRAM; the display read path is on the other port and is untouched.
- Shares the write port between two requesters: A (drawing engine) and B (image loader).
- Also runs a built-in clear engine that fills the whole canvas with one colour.
- Optional vertical-blank gating keeps all writes out of the active scan region.

---
 rtl/vram_wr_arbiter.sv | 118 +++++++++++
 tb/tb_vram_wr_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vram_wr_arbiter.sv
// Single write port of the frame-buffer BRAM: round-robin A/B writes plus a full-canvas clear engine.
// Latency: request or clear step sampled at edge k shows as ack/we/waddr/wdata in cycle k+1.
// Backpressure: requests wait (no ack) during a clear or while vblank gating is closed.
module vram_wr_arbiter #(
  parameter int AW    = 15,
  parameter int H_LEN = 200,
  parameter int V_LEN = 150
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          vblank,
  input  logic          vb_only,
  input  logic          clr_start,
  input  logic [11:0]   clr_color,
  output logic          clr_busy,
  output logic          clr_done,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  input  logic [11:0]   a_data,
  output logic          a_ack,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  input  logic [11:0]   b_data,
  output logic          b_ack,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [11:0]   wdata
);

  localparam int            DEPTH     = H_LEN * V_LEN;
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  logic          last_b;
  logic          sweep_end;
  logic [AW-1:0] cnt;
  logic [11:0]   clr_col;

  logic wr_ok, a_elig, b_elig, pick_a, pick_b, a_in_rng, b_in_rng;

  assign wr_ok    = !vb_only || vblank;
  // A requester acked this cycle is still holding req; skip it once.
  assign a_elig   = a_req && !a_ack;
  assign b_elig   = b_req && !b_ack;
  assign pick_b   = b_elig && (!a_elig || !last_b);
  assign pick_a   = a_elig && !pick_b;
  assign a_in_rng = {1'b0, a_addr} < DEPTH_W;
  assign b_in_rng = {1'b0, b_addr} < DEPTH_W;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      sweep_end <= 1'b0;
      cnt       <= '0;
      clr_col   <= '0;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
    end else begin
      we       <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state     <= CLEAR;
            clr_col   <= clr_color;
            cnt       <= '0;
            sweep_end <= 1'b0;
            clr_busy  <= 1'b1;
          end else if (wr_ok && (pick_a || pick_b)) begin
            last_b <= pick_b;
            // Out-of-range writes are acked but dropped; waddr/wdata keep their last value.
            if (pick_a) begin
              a_ack <= 1'b1;
              if (a_in_rng) begin
                we    <= 1'b1;
                waddr <= a_addr;
                wdata <= a_data;
              end
            end else begin
              b_ack <= 1'b1;
              if (b_in_rng) begin
                we    <= 1'b1;
                waddr <= b_addr;
                wdata <= b_data;
              end
            end
          end
        end
        CLEAR: begin
          if (sweep_end) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else if (wr_ok) begin
            we    <= 1'b1;
            waddr <= cnt;
            wdata <= clr_col;
            if (cnt == LAST_ADDR) sweep_end <= 1'b1;
            else                  cnt       <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_wr_arbiter.sv
// Directed bench for vram_wr_arbiter on a reduced 50x40 canvas so full clears stay short.
module tb_vram_wr_arbiter;

  localparam int AW    = 15;
  localparam int H_LEN = 50;
  localparam int V_LEN = 40;
  localparam int DEPTH = H_LEN * V_LEN;

  logic          pclk = 1'b0;
  logic          rst, vblank, vb_only, clr_start;
  logic [11:0]   clr_color;
  logic          clr_busy, clr_done;
  logic          a_req, b_req, a_ack, b_ack;
  logic [AW-1:0] a_addr, b_addr, waddr;
  logic [11:0]   a_data, b_data, wdata;
  logic          we;

  int n_checks = 0;
  int n_fail   = 0;

  vram_wr_arbiter #(.AW(AW), .H_LEN(H_LEN), .V_LEN(V_LEN)) dut (
    .pclk(pclk), .rst(rst), .vblank(vblank), .vb_only(vb_only),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
    .we(we), .waddr(waddr), .wdata(wdata)
  );

  always #5 pclk = ~pclk;

  // Frame-buffer model: write counts, contents and gating violations.
  int          wcount [DEPTH];
  logic [11:0] fb     [DEPTH];
  int          wr_total  = 0;
  int          gate_viol = 0;
  int          done_cnt  = 0;
  logic        vb_s  = 1'b0;
  logic        vbo_s = 1'b0;

  always @(posedge pclk) begin
    vb_s  <= vblank;
    vbo_s <= vb_only;
  end

  always @(negedge pclk) begin
    if (we) begin
      wr_total = wr_total + 1;
      if (int'(waddr) < DEPTH) begin
        wcount[int'(waddr)] = wcount[int'(waddr)] + 1;
        fb[int'(waddr)]     = wdata;
      end
      if (vbo_s && !vb_s) gate_viol = gate_viol + 1;
    end
    if (clr_done) done_cnt = done_cnt + 1;
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int base [DEPTH];
  int wr0, done0, viol0, bad, c;
  logic seen;

  initial begin
    for (int i = 0; i < DEPTH; i++) wcount[i] = 0;
    rst = 1'b1; vblank = 1'b0; vb_only = 1'b0; clr_start = 1'b0; clr_color = '0;
    a_req = 1'b0; a_addr = '0; a_data = '0;
    b_req = 1'b0; b_addr = '0; b_data = '0;
    tick(); tick();
    check("reset_outputs", {we, a_ack, b_ack, clr_busy, clr_done}, 5'b0);
    check("reset_waddr_wdata", {waddr, wdata}, '0);
    rst = 1'b0;
    tick();

    // A alone, held one extra edge
    a_req = 1'b1; a_addr = 15'd5; a_data = 12'hF00;
    tick();
    check("a_single_grant", {a_ack, b_ack, we, waddr, wdata}, {1'b1, 1'b0, 1'b1, 15'd5, 12'hF00});
    tick();
    check("a_no_double_ack", {a_ack, we}, 2'b00);
    check("a_hold_waddr_wdata", {waddr, wdata}, {15'd5, 12'hF00});
    a_req = 1'b0;
    tick();

    // Fresh reset, then A and B held: A,B,A,B
    rst = 1'b1; tick(); rst = 1'b0; tick();
    a_req = 1'b1; a_addr = 15'd10; a_data = 12'h111;
    b_req = 1'b1; b_addr = 15'd20; b_data = 12'h222;
    tick();
    check("rr_1_A", {a_ack, b_ack, we, waddr}, {2'b10, 1'b1, 15'd10});
    tick();
    check("rr_2_B", {a_ack, b_ack, we, waddr}, {2'b01, 1'b1, 15'd20});
    tick();
    check("rr_3_A", {a_ack, b_ack, we, waddr}, {2'b10, 1'b1, 15'd10});
    tick();
    check("rr_4_B", {a_ack, b_ack, we, waddr, wdata}, {2'b01, 1'b1, 15'd20, 12'h222});
    a_req = 1'b0; b_req = 1'b0;
    tick();

    // Out-of-range and last in-range address
    wr0 = wr_total;
    a_req = 1'b1; a_addr = 15'd2000; a_data = 12'h123;
    tick();
    check("oor_ack_no_we", {a_ack, we, waddr, wdata}, {1'b1, 1'b0, 15'd20, 12'h222});
    a_req = 1'b0;
    tick();
    check("oor_no_fb_write", 64'(wr_total - wr0), 64'd0);
    a_req = 1'b1; a_addr = 15'd1999; a_data = 12'h321;
    tick();
    check("last_addr_write", {a_ack, we, waddr, wdata}, {1'b1, 1'b1, 15'd1999, 12'h321});
    a_req = 1'b0;
    tick();

    // Full clear with vb_only=0 while B waits
    for (int i = 0; i < DEPTH; i++) base[i] = wcount[i];
    done0 = done_cnt;
    clr_start = 1'b1; clr_color = 12'h0F0;
    b_req = 1'b1; b_addr = 15'd77; b_data = 12'hABC;
    tick();
    check("clr_start_beats_req", {clr_busy, we, b_ack}, 3'b100);
    clr_start = 1'b0; clr_color = 12'h000;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      check("clr_sweep", {we, b_ack, clr_busy, waddr, wdata}, {3'b101, 15'(i), 12'h0F0});
    end
    tick();
    check("clr_done_pulse", {clr_done, clr_busy, we, b_ack}, 4'b1000);
    tick();
    check("b_after_clear", {clr_done, b_ack, we, waddr, wdata}, {2'b01, 1'b1, 15'd77, 12'hABC});
    b_req = 1'b0;
    tick();
    check("b_ack_single", {b_ack, we}, 2'b00);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wcount[i] - base[i] != ((i == 77) ? 2 : 1)) bad++;
      if (fb[i] !== ((i == 77) ? 12'hABC : 12'h0F0)) bad++;
    end
    check("clr_fb_contents", 64'(bad), 64'd0);
    check("clr_done_count", 64'(done_cnt - done0), 64'd1);

    // Clear gated by vblank toggling every 100 cycles; a second clr_start mid-clear is ignored
    for (int i = 0; i < DEPTH; i++) base[i] = wcount[i];
    done0 = done_cnt; viol0 = gate_viol; wr0 = wr_total;
    vb_only = 1'b1; vblank = 1'b0;
    clr_start = 1'b1; clr_color = 12'h00F;
    tick();
    clr_start = 1'b0; clr_color = 12'h000;
    tick();
    check("vb_paused", {clr_busy, we}, 2'b10);
    c = 0; seen = 1'b0;
    while (!seen && c < 20 * DEPTH) begin
      c++;
      if (c == 50) begin clr_start = 1'b1; clr_color = 12'h555; end
      else clr_start = 1'b0;
      if (c % 100 == 0) vblank = ~vblank;
      tick();
      if (clr_done) seen = 1'b1;
    end
    check("vb_done_seen", 64'(seen), 64'd1);
    check("vb_gate_viol", 64'(gate_viol - viol0), 64'd0);
    check("vb_write_total", 64'(wr_total - wr0), 64'(DEPTH));
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wcount[i] - base[i] != 1) bad++;
      if (fb[i] !== 12'h00F) bad++;
    end
    check("vb_each_addr_once", 64'(bad), 64'd0);
    tick();
    check("vb_done_count", 64'(done_cnt - done0), 64'd1);
    check("vb_idle_after", {clr_busy, clr_done}, 2'b00);
    vb_only = 1'b0; vblank = 1'b0;

    // Async reset mid-clear at cnt=1234, then restart from 0
    clr_start = 1'b1; clr_color = 12'h0AA;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 1235; i++) tick();
    check("pre_rst_cnt", {we, waddr, wdata}, {1'b1, 15'd1234, 12'h0AA});
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", {we, clr_busy, clr_done, a_ack, b_ack, waddr, wdata}, '0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", {we, clr_busy, clr_done}, 3'b000);
    clr_start = 1'b1; clr_color = 12'h0AA;
    tick();
    check("restart_busy", {clr_busy, we}, 2'b10);
    clr_start = 1'b0;
    tick();
    check("restart_addr0", {we, waddr, wdata}, {1'b1, 15'd0, 12'h0AA});
    tick();
    check("restart_addr1", {we, waddr}, {1'b1, 15'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
